fft_out_buf64: RTL and testbench
================================

FFT_OUT_BUF64 -- requirements
Module: fft_out_buf64

Interface
REQ-001 Parameter BITREV, default 0; 1 means input samples arrive in bit-reversed bin order and SHALL be written to buffer address bitrev6(count).
REQ-002 Parameter W, default 16; sample width per component.
REQ-003 CLK input 1: single clock; all logic on rising edge.
REQ-004 RST input 1: reset, asynchronous assert, active-low.
REQ-005 ED input 1: data enable; all inputs sampled only when ED=1.
REQ-006 RDY input 1: first-sample-of-frame strobe from FFT pipeline, qualified by ED.
REQ-007 DR input W: real part of FFT output sample, two's complement.
REQ-008 DI input W: imaginary part, two's complement.
REQ-009 RD_START input 1: single-cycle request to stream out the captured frame.
REQ-010 DOR output W: readout real part.
REQ-011 DOI output W: readout imaginary part.
REQ-012 DOV output 1: DOR/DOI valid.
REQ-013 DOA output 6: natural-order bin index of current readout sample.
REQ-014 FULL output 1: complete 64-sample frame held, not yet read.
REQ-015 PEAK_BIN output 6: bin with largest L1 magnitude in last completed frame.
REQ-016 PEAK_MAG output W+1: that magnitude, unsigned.
REQ-017 OVERRUN output 1: sticky; frame start arrived while a frame was held or being read.

Function
REQ-018 FSM states IDLE, CAPTURE, FULL, READOUT; reset state IDLE.
REQ-019 IDLE: ED=1 and RDY=1 writes sample to bin 0, count:=1, -> CAPTURE.
REQ-020 CAPTURE: each ED=1 cycle writes sample to bin count (BITREV=0) or bitrev6(count) (BITREV=1), count+1; ED=0 cycles hold.
REQ-021 CAPTURE: ED=1 and RDY=1 with count!=0 restarts frame: sample to bin 0, count:=1, peak tracker cleared; no error flag.
REQ-022 Write of count=63 -> FULL next cycle; FULL=1 from that cycle; PEAK_BIN/PEAK_MAG updated same cycle.
REQ-023 Magnitude = |DR|+|DI|, W+1 bits unsigned; |-2^(W-1)| = 2^(W-1) exact, no saturation.
REQ-024 Peak tracking: strict greater-than replaces; ties keep lower natural bin (BITREV=1 compares natural bin index on tie).
REQ-025 FULL: RD_START=1 -> READOUT; ED=1 and RDY=1 sets OVERRUN, sample discarded, frame kept.
REQ-026 READOUT: buffer read in natural order 0..63, one per cycle, no stalls; first DOV=1 exactly 2 cycles after RD_START cycle (registered address + registered read).
REQ-027 DOV=1 for exactly 64 consecutive cycles with DOA=0..63; after bin 63, FULL:=0, -> IDLE.
REQ-028 READOUT: ED=1 and RDY=1 sets OVERRUN, ignored; RD_START ignored.
REQ-029 RD_START in IDLE or CAPTURE ignored.
REQ-030 DOV=0 outside readout; DOR/DOI/DOA hold last value when DOV=0.
REQ-031 OVERRUN cleared only by reset.

Reset
REQ-032 RST=0 forces immediately: state IDLE, count 0, FULL 0, DOV 0, DOR 0, DOI 0, DOA 0, PEAK_BIN 0, PEAK_MAG 0, OVERRUN 0.
REQ-033 Buffer RAM contents not reset; reset mid-capture or mid-readout discards frame.

Structure
REQ-034 Shared package fft64_pkg: N=64, LOG2N=6, state enumeration, bitrev6 function.
REQ-035 One sub-module fft_buf_ram64: 64 x 2W dual-port RAM, one write port, one registered read port, no reset.

Verification
REQ-036 Impulse: 64 samples DR=16'h7FFC, DI=0, ED=1 always, RDY on first -> FULL after 64 cycles; readout all bins 7FFC/0000; PEAK_BIN=0, PEAK_MAG=17'h07FFC.
REQ-037 Two tones: bin 1 = (16'h4000,0), bin 61 = (0,16'hC000), others 0 -> PEAK_BIN=1 (tie, lower bin), PEAK_MAG=17'h04000.
REQ-038 ED toggled every other cycle, BITREV=1, sample value = arrival index -> readout DOA=k gives DOR=bitrev6(k); capture spans 127 cycles.
REQ-039 Extreme: bin 5 = (16'h8000,16'h8000) -> PEAK_BIN=5, PEAK_MAG=17'h10000.
REQ-040 RDY during FULL and during READOUT -> OVERRUN=1, readout data unchanged, 64 DOV cycles; RDY at count=20 in CAPTURE -> restart, OVERRUN stays 0.
REQ-041 RST low at readout bin 30 -> DOV=0 and FULL=0 same cycle; next RDY frame captured normally.

Source files
------------

// File: rtl/fft64_pkg.sv
// Shared constants, state encoding and index helpers for the 64-point FFT
// output buffer.
package fft64_pkg;

    localparam int N     = 64;
    localparam int LOG2N = 6;

    localparam logic [LOG2N-1:0] LAST_BIN = 6'd63;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_FULL,
        S_READOUT
    } buf_state_t;

    function automatic logic [LOG2N-1:0] bitrev6(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_buf_ram64.sv
// 64-entry simple dual-port frame store: one write port, one registered read
// port, no reset on contents or read data.
module fft_buf_ram64
    import fft64_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic             clk,
    input  logic             we,
    input  logic [LOG2N-1:0] waddr,
    input  logic [DW-1:0]    wdata,
    input  logic             re,
    input  logic [LOG2N-1:0] raddr,
    output logic [DW-1:0]    rdata
);

    logic [DW-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_out_buf64.sv
// Captures one 64-sample FFT frame (natural or bit-reversed arrival order),
// tracks the L1-magnitude peak bin, and streams the frame out in natural order.
module fft_out_buf64
    import fft64_pkg::*;
#(
    parameter int BITREV = 0,
    parameter int W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ED,
    input  logic             RDY,
    input  logic [W-1:0]     DR,
    input  logic [W-1:0]     DI,
    input  logic             RD_START,
    output logic [W-1:0]     DOR,
    output logic [W-1:0]     DOI,
    output logic             DOV,
    output logic [LOG2N-1:0] DOA,
    output logic             FULL,
    output logic [LOG2N-1:0] PEAK_BIN,
    output logic [W:0]       PEAK_MAG,
    output logic             OVERRUN
);

    buf_state_t       state, state_nx;
    logic [LOG2N-1:0] cnt, cnt_nx, wr_idx, waddr;
    logic             we, restart, last, ovr_set;
    logic             rd_en, iss_start, iss_busy;
    logic [LOG2N-1:0] iss, raddr;
    logic             v1;
    logic [LOG2N-1:0] a1;
    logic [2*W-1:0]   q;
    logic [W:0]       mag, run_mag;
    logic [LOG2N-1:0] run_bin;
    logic             better;

    // The most negative input maps to 2^(W-1), which still fits W bits unsigned.
    function automatic logic [W-1:0] abs_w(input logic [W-1:0] x);
        return x[W-1] ? ((~x) + W'(1)) : x;
    endfunction

    assign wr_idx = (BITREV != 0) ? bitrev6(cnt) : cnt;
    assign mag    = {1'b0, abs_w(DR)} + {1'b0, abs_w(DI)};
    // Buffer address is the natural bin, so the tie rule works in either order.
    assign better = restart || (mag > run_mag) ||
                    ((mag == run_mag) && (waddr < run_bin));
    assign FULL   = (state == S_FULL) || (state == S_READOUT);

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        we        = 1'b0;
        waddr     = wr_idx;
        restart   = 1'b0;
        last      = 1'b0;
        ovr_set   = 1'b0;
        rd_en     = 1'b0;
        raddr     = iss;
        iss_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (ED && RDY) begin
                    we       = 1'b1;
                    waddr    = '0;
                    restart  = 1'b1;
                    cnt_nx   = 6'd1;
                    state_nx = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (ED) begin
                    we = 1'b1;
                    if (RDY) begin
                        waddr   = '0;
                        restart = 1'b1;
                        cnt_nx  = 6'd1;
                    end else begin
                        cnt_nx = cnt + 6'd1;
                        if (cnt == LAST_BIN) begin
                            last     = 1'b1;
                            state_nx = S_FULL;
                        end
                    end
                end
            end
            S_FULL: begin
                ovr_set = ED && RDY;
                if (RD_START) begin
                    // Address 0 is issued straight from the request cycle.
                    rd_en     = 1'b1;
                    raddr     = '0;
                    iss_start = 1'b1;
                    state_nx  = S_READOUT;
                end
            end
            S_READOUT: begin
                ovr_set = ED && RDY;
                rd_en   = iss_busy;
                if (DOV && (DOA == LAST_BIN)) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            run_mag  <= '0;
            run_bin  <= '0;
            PEAK_MAG <= '0;
            PEAK_BIN <= '0;
        end else begin
            if (we && better) begin
                run_mag <= mag;
                run_bin <= waddr;
            end
            if (last) begin
                PEAK_MAG <= better ? mag : run_mag;
                PEAK_BIN <= better ? waddr : run_bin;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            OVERRUN <= 1'b0;
        end else if (ovr_set) begin
            OVERRUN <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            iss      <= '0;
            iss_busy <= 1'b0;
        end else if (iss_start) begin
            iss      <= 6'd1;
            iss_busy <= 1'b1;
        end else if ((state == S_READOUT) && iss_busy) begin
            iss <= iss + 6'd1;
            if (iss == LAST_BIN) begin
                iss_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            v1  <= 1'b0;
            a1  <= '0;
            DOV <= 1'b0;
            DOA <= '0;
            DOR <= '0;
            DOI <= '0;
        end else begin
            v1  <= rd_en;
            a1  <= raddr;
            DOV <= v1;
            if (v1) begin
                DOA <= a1;
                DOR <= q[2*W-1:W];
                DOI <= q[W-1:0];
            end
        end
    end

    fft_buf_ram64 #(
        .DW (2 * W)
    ) u_ram (
        .clk   (CLK),
        .we    (we),
        .waddr (waddr),
        .wdata ({DR, DI}),
        .re    (rd_en),
        .raddr (raddr),
        .rdata (q)
    );

endmodule

// File: tb/tb_fft_out_buf64.sv
// Directed bench for fft_out_buf64: natural-order and bit-reversed instances
// share stimulus; expected values are hand-derived constants and arrays.
module tb_fft_out_buf64;

    localparam int W = 16;

    logic          CLK = 1'b0;
    logic          RST, ED, RDY, RD_START;
    logic [W-1:0]  DR, DI;

    logic [W-1:0]  DOR_a, DOI_a, DOR_b, DOI_b;
    logic          DOV_a, DOV_b, FULL_a, FULL_b, OVERRUN_a, OVERRUN_b;
    logic [5:0]    DOA_a, DOA_b, PEAK_BIN_a, PEAK_BIN_b;
    logic [W:0]    PEAK_MAG_a, PEAK_MAG_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] fr_r [64];
    logic [W-1:0] fr_i [64];
    logic [W-1:0] exp_r [64];
    logic [W-1:0] exp_i [64];

    always #5 CLK = ~CLK;

    fft_out_buf64 #(.BITREV(0), .W(W)) u_dut (
        .CLK(CLK), .RST(RST), .ED(ED), .RDY(RDY), .DR(DR), .DI(DI),
        .RD_START(RD_START), .DOR(DOR_a), .DOI(DOI_a), .DOV(DOV_a),
        .DOA(DOA_a), .FULL(FULL_a), .PEAK_BIN(PEAK_BIN_a),
        .PEAK_MAG(PEAK_MAG_a), .OVERRUN(OVERRUN_a)
    );

    fft_out_buf64 #(.BITREV(1), .W(W)) u_dut_br (
        .CLK(CLK), .RST(RST), .ED(ED), .RDY(RDY), .DR(DR), .DI(DI),
        .RD_START(RD_START), .DOR(DOR_b), .DOI(DOI_b), .DOV(DOV_b),
        .DOA(DOA_b), .FULL(FULL_b), .PEAK_BIN(PEAK_BIN_b),
        .PEAK_MAG(PEAK_MAG_b), .OVERRUN(OVERRUN_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [5:0] rev6(input logic [5:0] a);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = a[5-i];
        return r;
    endfunction

    function automatic logic [63:0] rd_obs(input bit use_br);
        return use_br ? 64'({DOV_b, DOA_b, DOR_b, DOI_b})
                      : 64'({DOV_a, DOA_a, DOR_a, DOI_a});
    endfunction

    // Streams fr_r/fr_i; RD_START is poked mid-capture and must be ignored.
    task automatic send_frame(input bit gap, input bit use_br);
        for (int k = 0; k < 64; k++) begin
            ED       = 1'b1;
            RDY      = (k == 0);
            DR       = fr_r[k];
            DI       = fr_i[k];
            RD_START = (k == 10);
            tick();
            RD_START = 1'b0;
            if (gap && k != 63) begin
                ED  = 1'b0;
                RDY = 1'b0;
                tick();
            end
            if (k == 62)
                check_eq("full_early", 64'(use_br ? FULL_b : FULL_a), 64'd0);
        end
        ED  = 1'b0;
        RDY = 1'b0;
        check_eq("full_set", 64'(use_br ? FULL_b : FULL_a), 64'd1);
        check_eq("dov_capture", 64'(use_br ? DOV_b : DOV_a), 64'd0);
    endtask

    task automatic set_exp_natural();
        for (int k = 0; k < 64; k++) begin
            exp_r[k] = fr_r[k];
            exp_i[k] = fr_i[k];
        end
    endtask

    // inj_at: bin at which RDY+RD_START are driven; rst_at: bin at which RST drops.
    task automatic readout(input bit use_br, input int inj_at, input int rst_at);
        RD_START = 1'b1;
        tick();
        RD_START = 1'b0;
        check_eq("rd_latency1", 64'(use_br ? DOV_b : DOV_a), 64'd0);
        tick();
        for (int k = 0; k < 64; k++) begin
            check_eq("rd_sample", rd_obs(use_br),
                     64'({1'b1, 6'(k), exp_r[k], exp_i[k]}));
            if (k == rst_at) begin
                RST = 1'b0;
                #1;
                check_eq("rst_mid_read", 64'({DOV_a, FULL_a, DOR_a}), 64'd0);
                @(posedge CLK);
                #1;
                RST = 1'b1;
                return;
            end
            if (k == inj_at) begin
                ED = 1'b1; RDY = 1'b1; RD_START = 1'b1;
                DR = 16'hFFFF; DI = 16'hFFFF;
            end
            tick();
            ED = 1'b0; RDY = 1'b0; RD_START = 1'b0;
        end
        check_eq("rd_end", rd_obs(use_br),
                 64'({1'b0, 6'd63, exp_r[63], exp_i[63]}));
        check_eq("rd_full_clr", 64'(use_br ? FULL_b : FULL_a), 64'd0);
    endtask

    task automatic clear_frame();
        for (int k = 0; k < 64; k++) begin
            fr_r[k] = '0;
            fr_i[k] = '0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST = 1'b0; ED = 1'b0; RDY = 1'b0; RD_START = 1'b0;
        DR = '0; DI = '0;
        #3;
        check_eq("reset_ctl", 64'({DOV_a, FULL_a, OVERRUN_a, DOA_a, PEAK_BIN_a}), 64'd0);
        check_eq("reset_data", 64'({DOR_a, DOI_a}), 64'd0);
        check_eq("reset_peak_mag", 64'(PEAK_MAG_a), 64'd0);
        tick();
        tick();
        RST = 1'b1;

        RD_START = 1'b1;
        tick();
        RD_START = 1'b0;
        tick();
        tick();
        check_eq("idle_rd_start", 64'({DOV_a, FULL_a}), 64'd0);

        // Impulse: every bin equal, tie keeps bin 0
        for (int k = 0; k < 64; k++) begin
            fr_r[k] = 16'h7FFC;
            fr_i[k] = 16'h0000;
        end
        send_frame(1'b0, 1'b0);
        check_eq("impulse_peak_bin", 64'(PEAK_BIN_a), 64'd0);
        check_eq("impulse_peak_mag", 64'(PEAK_MAG_a), 64'h07FFC);
        set_exp_natural();
        readout(1'b0, -1, -1);

        // Two tones of equal magnitude
        clear_frame();
        fr_r[1]  = 16'h4000;
        fr_i[61] = 16'hC000;
        send_frame(1'b0, 1'b0);
        check_eq("tones_peak_bin", 64'(PEAK_BIN_a), 64'd1);
        check_eq("tones_peak_mag", 64'(PEAK_MAG_a), 64'h04000);
        set_exp_natural();
        readout(1'b0, -1, -1);

        // Most negative components vs. near-maximum positive ones
        clear_frame();
        fr_r[5] = 16'h8000; fr_i[5] = 16'h8000;
        fr_r[9] = 16'h7FFF; fr_i[9] = 16'h7FFF;
        send_frame(1'b0, 1'b0);
        check_eq("extreme_peak_bin", 64'(PEAK_BIN_a), 64'd5);
        check_eq("extreme_peak_mag", 64'(PEAK_MAG_a), 64'h10000);
        set_exp_natural();
        readout(1'b0, -1, -1);

        // Bit-reversed arrival with ED gaps: arrival j lands at bin rev6(j)
        for (int k = 0; k < 64; k++) begin
            fr_r[k] = 16'(k);
            fr_i[k] = 16'(k * 16);
        end
        send_frame(1'b1, 1'b1);
        check_eq("br_peak_bin", 64'(PEAK_BIN_b), 64'd63);
        check_eq("br_peak_mag", 64'(PEAK_MAG_b), 64'h0042F);
        for (int k = 0; k < 64; k++) begin
            exp_r[k] = fr_r[rev6(6'(k))];
            exp_i[k] = fr_i[rev6(6'(k))];
        end
        readout(1'b1, -1, -1);

        // Restart at count 20: large partial frame must not leak into the peak
        for (int k = 0; k < 20; k++) begin
            ED = 1'b1; RDY = (k == 0);
            DR = 16'h7FFF; DI = 16'h7FFF;
            tick();
        end
        for (int k = 0; k < 64; k++) begin
            fr_r[k] = 16'(k) - 16'd20;
            fr_i[k] = 16'(k) - 16'd20;
        end
        send_frame(1'b0, 1'b0);
        check_eq("restart_overrun", 64'(OVERRUN_a), 64'd0);
        check_eq("restart_peak_bin", 64'(PEAK_BIN_a), 64'd63);
        check_eq("restart_peak_mag", 64'(PEAK_MAG_a), 64'h00056);

        // Frame start while full: flagged, sample discarded
        ED = 1'b1; RDY = 1'b1; DR = 16'h1234; DI = 16'h1234;
        tick();
        ED = 1'b0; RDY = 1'b0;
        check_eq("full_overrun", 64'({OVERRUN_a, FULL_a, DOV_a}), 64'b110);
        set_exp_natural();
        readout(1'b0, 17, -1);
        check_eq("overrun_sticky", 64'(OVERRUN_a), 64'd1);

        // Reset during readout, then a normal frame
        clear_frame();
        fr_r[1]  = 16'h4000;
        fr_i[61] = 16'hC000;
        send_frame(1'b0, 1'b0);
        set_exp_natural();
        readout(1'b0, -1, 30);
        check_eq("post_rst_state", 64'({OVERRUN_a, FULL_a, DOV_a, PEAK_BIN_a}), 64'd0);
        check_eq("post_rst_peak_mag", 64'(PEAK_MAG_a), 64'd0);

        clear_frame();
        fr_r[5] = 16'h8000; fr_i[5] = 16'h8000;
        fr_r[9] = 16'h7FFF; fr_i[9] = 16'h7FFF;
        send_frame(1'b0, 1'b0);
        check_eq("post_rst_peak_bin", 64'(PEAK_BIN_a), 64'd5);
        check_eq("pre_read_overrun", 64'(OVERRUN_a), 64'd0);
        set_exp_natural();
        readout(1'b0, 10, -1);
        check_eq("read_overrun", 64'(OVERRUN_a), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
